seg7_result_display: RTL and testbench
======================================

Name: seg7_result_display

Overview:
- Downstream consumer of the SoC's 16-bit memory-mapped `result` word; drives an 8-digit multiplexed seven-segment display on the board.
- Converts the value to decimal (5 digits) with a sequential double-dabble engine, or shows it as 4 hex digits.
- Scans the digits using a time-multiplexed anode sequence.
- Runs on the CPU clock domain next to the SoC top.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays lit (≥2).
- BLANK_LZ, 1, 1 = blank leading zeros (the least-significant digit is always shown).

Ports:
- clk  input  1  CPU clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- value  input  16  binary word to display (the SoC `result`).
- hex_mode  input  1  1 = hexadecimal display, 0 = decimal display.
- busy  output  1  high while a conversion is in progress.
- an  output  8  digit enables, active-low, one-hot; an[0] is the rightmost digit.
- seg  output  8  segments, active-low; seg[0]=a … seg[6]=g, seg[7]=dp.

Behaviour:
- Reset (asynchronous, active-high):
  - an=8'hFF, seg=8'hFF, busy=0.
  - Latched value and latched mode = 0.
  - Display nibble registers = 0, digit index = 0, divider = 0, FSM = IDLE.
  - Reset asserted mid-conversion aborts it; no partial result is committed.
- Converter FSM, states IDLE → SHIFT → COMMIT → IDLE:
  - IDLE: if (value != latched value) or (hex_mode != latched mode), latch both, clear the 20-bit BCD accumulator, load the shift register, counter=0, go to SHIFT. Otherwise stay.
  - SHIFT, 16 cycles:
    - First, every BCD nibble ≥5 gets +3.
    - Then {bcd, shreg} shifts left by 1, taking in the MSB.
    - When counter==15, go to COMMIT.
  - COMMIT, 1 cycle:
    - Display registers take the BCD digits (decimal) or value[15:0] nibbles (hex), all at once, so the display never shows a torn value.
    - Go to IDLE.
  - In hex mode the conversion still runs the full 16 cycles, so latency is constant.
- busy is high in SHIFT and COMMIT only.
- Latency: a change sampled in IDLE at edge N gives SHIFT on edges N+1..N+16 and COMMIT at N+17. The new digits are visible from edge N+18.
- `value` changes during SHIFT/COMMIT are ignored. The IDLE compare after COMMIT picks up the final value, so the last value written is always displayed.
- Digit activity:
  - Decimal: digits 0–4 are active, digits 5–7 blank.
  - Hex: digits 0–3 are active, digits 4–7 blank.
- Leading-zero blanking (BLANK_LZ=1): a zero digit is blanked if every more-significant active digit is also zero. Digit 0 is never blanked.
- Scan:
  - The divider counts 0..SCAN_DIV-1. On wrap, the digit index increments mod 8 (7 → 0).
  - an and seg are registered from the current index, one cycle after the index changes.
  - A blank digit keeps its an bit low (uniform timing) with seg=8'hFF.
  - dp is always off (seg[7]=1).
- Segment encoding covers 0–F: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.

Decomposition:
- Package seg7_pkg holds:
  - FSM state enum (IDLE, SHIFT, COMMIT).
  - SEG_BLANK=8'hFF.
  - 16-entry segment lookup constant.
  - DEC_DIGITS=5, HEX_DIGITS=4.
- Sub-module bin2bcd_seq: the 16-bit sequential double-dabble engine.
  - Ports: clk, reset, start, bin[15:0], busy, done, bcd[19:0].
  - The top holds the change detect, display registers, blanking and scanner.

Test Plan:
- Reset check, SCAN_DIV=4: hold reset 3 cycles, release with value=0 -> an=FF and seg=FF during reset; busy never rises. After reset: digit 0 shows C0, digits 1–7 blank; an walks FE, FD, …, 7F, changing every 4 cycles and wrapping to FE.
- Decimal conversion: value 0→12345 (0x3039), decimal -> busy high for exactly 17 cycles. Display registers = 1,2,3,4,5 from edge N+18; digit 4 seg=F9, digit 0 seg=92.
- Maximum value: value=65535, decimal -> digits 6,5,5,3,5 (82, 92, 92, B0, 92); digits 5–7 blank.
- Hex mode: hex_mode=1 with value=0xBEEF -> a conversion is triggered by the mode change. Digits 3..0 = 83, 86, 86, 8E; digits 4–7 blank.
- Change mid-conversion: value=100, then value=7 at cycle 5 of SHIFT -> 100 is committed first, then a second conversion starts. Final display: digit 0 = F8, digits 1–4 blank (BLANK_LZ=1); with BLANK_LZ=0, digits 1–4 = C0.
- Reset during conversion: assert reset at SHIFT cycle 8 -> outputs go to FF immediately. After release the display shows 0; the new value is converted once it differs from 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the result display: converter states,
// digit counts and the active-low seven-segment glyph table.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_e;

    localparam int NUM_DIGITS = 8;
    localparam int DEC_DIGITS = 5;
    localparam int HEX_DIGITS = 4;
    localparam int BCD_W      = 4 * DEC_DIGITS;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Entry n is the glyph for nibble n; bit 0 = segment a, bit 7 = dp (kept off).
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit double-dabble converter: one shift per clock, 16 shifts,
// then a one-cycle COMMIT during which done is high and bcd holds the result.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [15:0]        bin,
    output logic               busy,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);

    conv_state_e        state_q;
    logic [15:0]        shreg_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [3:0]         cnt_q;
    logic               busy_q;
    logic               done_q;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W+15:0]  shift_d;

    // Add-3 correction on every BCD nibble before the shift.
    generate
        for (genvar gi = 0; gi < DEC_DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 :
                                        bcd_q[gi*4 +: 4];
        end
    endgenerate

    assign shift_d = {bcd_adj, shreg_q} << 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        shreg_q <= bin;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q   <= shift_d[BCD_W+15:16];
                    shreg_q <= shift_d[15:0];
                    cnt_q   <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        done_q  <= 1'b1;
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_result_display.sv
// Shows the SoC result word on an 8-digit multiplexed seven-segment display,
// in decimal (via bin2bcd_seq) or hex, with optional leading-zero blanking.
module seg7_result_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        hex_mode,
    output logic        busy,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [15:0]                value_q;
    logic                       mode_q;
    logic [DEC_DIGITS-1:0][3:0] disp_q;
    logic                       disp_mode_q;
    logic [DIV_W-1:0]           div_q;
    logic [2:0]                 idx_q;
    logic [7:0]                 an_q;
    logic [7:0]                 seg_q;

    logic                       eng_busy;
    logic                       eng_done;
    logic [BCD_W-1:0]           eng_bcd;
    logic                       start;

    logic [NUM_DIGITS-1:0][3:0] nib;
    logic [NUM_DIGITS-1:0]      upper_zero;
    logic [NUM_DIGITS-1:0]      blank;

    assign start = !eng_busy && ((value != value_q) || (hex_mode != mode_q));

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (value),
        .busy  (eng_busy),
        .done  (eng_done),
        .bcd   (eng_bcd)
    );

    // The hex path rides the same converter run so the latency is mode-independent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q     <= '0;
            mode_q      <= 1'b0;
            disp_q      <= '0;
            disp_mode_q <= 1'b0;
        end else begin
            if (start) begin
                value_q <= value;
                mode_q  <= hex_mode;
            end
            if (eng_done) begin
                disp_mode_q <= mode_q;
                disp_q      <= mode_q ? {4'h0, value_q} : eng_bcd;
            end
        end
    end

    // upper_zero[i]: digit i and every digit above it hold zero.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic active;

            if (gi < DEC_DIGITS) begin : g_nib
                assign nib[gi] = disp_q[gi];
            end else begin : g_nib_none
                assign nib[gi] = 4'h0;
            end

            if (gi == NUM_DIGITS - 1) begin : g_top
                assign upper_zero[gi] = (nib[gi] == 4'h0);
            end else begin : g_chain
                assign upper_zero[gi] = (nib[gi] == 4'h0) && upper_zero[gi+1];
            end

            assign active = (gi < (disp_mode_q ? HEX_DIGITS : DEC_DIGITS));

            if (gi == 0) begin : g_lsd
                assign blank[gi] = !active;
            end else begin : g_msd
                assign blank[gi] = !active || ((BLANK_LZ != 0) && upper_zero[gi]);
            end
        end
    endgenerate

    // Blank digits still get their anode slot so every digit has equal on-time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            idx_q <= '0;
            an_q  <= 8'hFF;
            seg_q <= SEG_BLANK;
        end else begin
            if (div_q == DIV_LAST) begin
                div_q <= '0;
                idx_q <= idx_q + 3'd1;
            end else begin
                div_q <= div_q + 1'b1;
            end
            an_q  <= ~(8'b1 << idx_q);
            seg_q <= blank[idx_q] ? SEG_BLANK : seg_encode(nib[idx_q]);
        end
    end

    assign busy = eng_busy;
    assign an   = an_q;
    assign seg  = seg_q;

endmodule

// File: tb/tb_seg7_result_display.sv
// Directed + randomized bench for seg7_result_display; expected glyphs come
// from an arithmetic model of the displayed number (powers of 10 / 16).
module tb_seg7_result_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        hex_mode;
    logic        busy, busy_nb;
    logic [7:0]  an, an_nb;
    logic [7:0]  seg, seg_nb;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #5 clk = ~clk;

    seg7_result_display #(.SCAN_DIV(4), .BLANK_LZ(1)) dut (
        .clk(clk), .reset(reset), .value(value), .hex_mode(hex_mode),
        .busy(busy), .an(an), .seg(seg)
    );

    seg7_result_display #(.SCAN_DIV(4), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .reset(reset), .value(value), .hex_mode(hex_mode),
        .busy(busy_nb), .an(an_nb), .seg(seg_nb)
    );

    function automatic logic [7:0] exp_seg(input int v, input bit hx, input int k, input bit blz);
        int base, cnt, p, d;
        base = hx ? 16 : 10;
        cnt  = hx ? 4 : 5;
        if (k >= cnt) return 8'hFF;
        p = 1;
        for (int i = 0; i < k; i++) p = p * base;
        d = (v / p) % base;
        if (blz && k > 0 && v < p) return 8'hFF;
        return seg_tbl[d];
    endfunction

    function automatic int find_k(input logic [7:0] a);
        int k = 0;
        for (int i = 7; i >= 0; i--) if (!a[i]) k = i;
        return k;
    endfunction

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic sweep(input int v, input bit hx, input string tag);
        int k, k2;
        for (int j = 0; j < 34; j++) begin
            @(negedge clk);
            k  = find_k(an);
            k2 = find_k(an_nb);
            chk8({tag, "_busy"},  {7'd0, busy}, 8'd0);
            chk8({tag, "_an"},    an, ~(8'b1 << k));
            chk8({tag, "_seg"},   seg, exp_seg(v, hx, k, 1'b1));
            chk8({tag, "_segnb"}, seg_nb, exp_seg(v, hx, k2, 1'b0));
        end
        $display("sweep %s value=%0d hex=%0d checked", tag, v, hx);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk8({tag, "_idle_timeout"}, {7'd0, busy}, 8'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n, v;
        bit hx;

        // Reset held for 3 cycles with value 0
        reset = 1'b1; value = 16'd0; hex_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk8("rst_an",   an,  8'hFF);
        chk8("rst_seg",  seg, 8'hFF);
        chk8("rst_busy", {7'd0, busy}, 8'd0);
        reset = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            chk8("walk_an",   an, ~(8'b1 << ((j / 4) % 8)));
            chk8("walk_seg",  seg, ((j / 4) % 8 == 0) ? 8'hC0 : 8'hFF);
            chk8("walk_busy", {7'd0, busy}, 8'd0);
        end
        $display("reset/scan walk checked");

        // Decimal 12345: exact busy window and display switch at N+18
        value = 16'd12345;
        for (int j = 0; j < 17; j++) begin
            @(negedge clk);
            chk8("lat_busy_hi", {7'd0, busy}, 8'd1);
        end
        @(negedge clk);
        chk8("lat_busy_lo", {7'd0, busy}, 8'd0);
        k = find_k(an);
        chk8("lat_old_seg", seg, exp_seg(0, 1'b0, k, 1'b1));
        @(negedge clk);
        k = find_k(an);
        chk8("lat_new_seg", seg, exp_seg(12345, 1'b0, k, 1'b1));
        $display("latency for 12345 checked");
        sweep(12345, 1'b0, "dec12345");

        value = 16'd65535;
        wait_idle("max");
        sweep(65535, 1'b0, "dec65535");

        // Mode change alone must trigger a conversion
        value = 16'hBEEF; hex_mode = 1'b1;
        wait_idle("hex");
        sweep(16'hBEEF, 1'b1, "hexBEEF");

        // Change during SHIFT: 100 commits first, then 7 is converted
        hex_mode = 1'b0; value = 16'd100;
        repeat (5) @(negedge clk);
        value = 16'd7;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk8("mid_timeout", {7'd0, busy}, 8'd0);
        @(negedge clk);
        k = find_k(an);
        chk8("mid_restart", {7'd0, busy}, 8'd1);
        chk8("mid_first",   seg, exp_seg(100, 1'b0, k, 1'b1));
        $display("mid-conversion change: 100 committed, restart seen");
        wait_idle("mid2");
        sweep(7, 1'b0, "dec7");

        // Reset during conversion
        value = 16'd4321;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk8("arst_an",    an,  8'hFF);
        chk8("arst_seg",   seg, 8'hFF);
        chk8("arst_busy",  {7'd0, busy}, 8'd0);
        chk8("arst_an_nb", an_nb, 8'hFF);
        value = 16'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sweep(0, 1'b0, "post_rst0");
        value = 16'd4321;
        wait_idle("post_rst");
        sweep(4321, 1'b0, "dec4321");

        // Randomized values and modes
        for (int it = 0; it < 10; it++) begin
            v  = int'($urandom_range(0, 65535));
            hx = 1'($urandom_range(0, 1));
            value = 16'(v); hex_mode = hx;
            wait_idle("rnd");
            sweep(v, hx, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
